// File: rtl/key_signal_decoder_if.sv
// PS/2 pin pair and decoded key-level bundle for key_signal_decoder.
// The decoder sits on the slave modport; the PS/2 source and the consumers sit on the master side.
interface key_signal_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       W_signal;
  logic       A_signal;
  logic       S_signal;
  logic       D_signal;
  logic       SPACE_signal;
  logic       ENTER_signal;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  W_signal,
    input  A_signal,
    input  S_signal,
    input  D_signal,
    input  SPACE_signal,
    input  ENTER_signal,
    input  byte_valid,
    input  byte_data,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output W_signal,
    output A_signal,
    output S_signal,
    output D_signal,
    output SPACE_signal,
    output ENTER_signal,
    output byte_valid,
    output byte_data,
    output frame_err
  );
endinterface

// File: rtl/key_signal_decoder.sv
// PS/2 scan-code set 2 receiver: deframes bytes, tracks make/break and drives held-key levels.
// Optional KEY_ARROW_ALIAS_EN makes the extended arrow keys alias W/A/S/D.
module key_signal_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic            clk,
  input logic            rst,
  key_signal_decoder_if.slave bus
);

  localparam int unsigned TcntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk
  } byte_state_e;

  // Key bit order: W, A, S, D, SPACE, ENTER
  localparam int unsigned KeyW     = 0;
  localparam int unsigned KeyA     = 1;
  localparam int unsigned KeyS     = 2;
  localparam int unsigned KeyD     = 3;
  localparam int unsigned KeySpace = 4;
  localparam int unsigned KeyEnter = 5;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Everything resets low so a falling edge is only seen
  // after a genuine high level has been sampled following reset.
  // ---------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      data_s1_q  <= 1'b0;
      data_s2_q  <= 1'b0;
    end else begin
      clk_s1_q   <= bus.ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= bus.ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // ---------------------------------------------------------------------------
  // Deframer with idle timeout
  // ---------------------------------------------------------------------------
  logic [10:0]      frame_q, frame_d, frame_shift;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             frame_good;

  assign frame_shift = {data_s2_q, frame_q[10:1]};
  assign frame_good  = ~frame_shift[0] & frame_shift[10] & (^frame_shift[9:1]);

  always_comb begin
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    tcnt_d    = tcnt_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      // An edge always wins over a timeout expiring in the same cycle.
      frame_d = frame_shift;
      tcnt_d  = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_good) begin
          valid_d = 1'b1;
          byte_d  = frame_shift[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tcnt_q == TcntW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        tcnt_d    = '0;
        err_d     = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TcntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q   <= '0;
      bit_cnt_q <= 4'd0;
      tcnt_q    <= '0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      tcnt_q    <= tcnt_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Make/break sequencer
  // ---------------------------------------------------------------------------
  byte_state_e state_q, state_d;
  logic [5:0]  key_q, key_d;
  logic [3:0]  arrow_q, arrow_d;
  logic        is_break, is_ext;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    arrow_d  = arrow_q;
    is_break = (state_q == StBrk) || (state_q == StExtBrk);
    is_ext   = (state_q == StExt) || (state_q == StExtBrk);
    if (valid_q) begin
      if (byte_q == 8'hE0) begin
        state_d = StExt;
      end else if (byte_q == 8'hF0 && state_q == StIdle) begin
        state_d = StBrk;
      end else if (byte_q == 8'hF0 && state_q == StExt) begin
        state_d = StExtBrk;
      end else begin
        state_d = StIdle;
        if (!is_ext) begin
          case (byte_q)
            8'h1D:   key_d[KeyW]     = ~is_break;
            8'h1C:   key_d[KeyA]     = ~is_break;
            8'h1B:   key_d[KeyS]     = ~is_break;
            8'h23:   key_d[KeyD]     = ~is_break;
            8'h29:   key_d[KeySpace] = ~is_break;
            8'h5A:   key_d[KeyEnter] = ~is_break;
            default: ;
          endcase
        end else begin
`ifdef KEY_ARROW_ALIAS_EN
          case (byte_q)
            8'h75:   arrow_d[KeyW] = ~is_break;
            8'h6B:   arrow_d[KeyA] = ~is_break;
            8'h72:   arrow_d[KeyS] = ~is_break;
            8'h74:   arrow_d[KeyD] = ~is_break;
            default: ;
          endcase
`else
          arrow_d = arrow_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      arrow_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      arrow_q <= arrow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.W_signal     = key_q[KeyW] | arrow_q[KeyW];
  assign bus.A_signal     = key_q[KeyA] | arrow_q[KeyA];
  assign bus.S_signal     = key_q[KeyS] | arrow_q[KeyS];
  assign bus.D_signal     = key_q[KeyD] | arrow_q[KeyD];
  assign bus.SPACE_signal = key_q[KeySpace];
  assign bus.ENTER_signal = key_q[KeyEnter];
  assign bus.byte_valid   = valid_q;
  assign bus.byte_data    = byte_q;
  assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_key_signal_decoder.sv
// Self-checking bench for key_signal_decoder: directed plan steps plus a random byte stream,
// checked against a key-held model built from the make/break/extended-prefix rules.
module tb_key_signal_decoder;

  localparam int unsigned T    = 100;
  localparam int          HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_signal_decoder_if bus ();

  key_signal_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [5:0] keys;
  assign keys = {bus.ENTER_signal, bus.SPACE_signal, bus.D_signal,
                 bus.S_signal, bus.A_signal, bus.W_signal};

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: which keys are held, plus pending prefix flags.
  bit [5:0] held;
  bit [3:0] arrow;
  bit       m_ext, m_brk;
  logic [7:0] last_byte;

  function automatic logic [5:0] model_keys();
    return held | {2'b00, arrow};
  endfunction

  task automatic model_reset();
    held = '0; arrow = '0; m_ext = 0; m_brk = 0; last_byte = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    last_byte = b;
    if (b == 8'hF0 && !m_brk) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else begin
      idx = -1;
      if (!m_ext) begin
        case (b)
          8'h1D: idx = 0; 8'h1C: idx = 1; 8'h1B: idx = 2;
          8'h23: idx = 3; 8'h29: idx = 4; 8'h5A: idx = 5;
          default: idx = -1;
        endcase
        if (idx >= 0) held[idx] = !m_brk;
      end else begin
`ifdef KEY_ARROW_ALIAS_EN
        case (b)
          8'h75: idx = 0; 8'h6B: idx = 1; 8'h72: idx = 2; 8'h74: idx = 3;
          default: idx = -1;
        endcase
        if (idx >= 0) arrow[idx] = !m_brk;
`endif
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a frame; a full frame gets exact E+1/E+2 checks,
  // a truncated one with wait_to set waits for the timeout pulse.
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits,
                            input bit wait_to);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ps2_data = f[i];
      repeat (HALF - 1) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) begin
        @(posedge clk); @(posedge clk); #1;
        check("pre_pulse", {30'd0, bus.byte_valid, bus.frame_err}, 32'd0);
        @(posedge clk); #1;
        if (!bad) model_byte(b);
        check("byte_valid", {31'd0, bus.byte_valid}, {31'd0, !bad});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, bad});
        check("byte_data", {24'd0, bus.byte_data}, {24'd0, last_byte});
        @(posedge clk); #1;
        check("pulse_width", {30'd0, bus.byte_valid, bus.frame_err}, 32'd0);
        check("keys", {26'd0, keys}, {26'd0, model_keys()});
        repeat (HALF - 4) @(negedge clk);
      end else if (i == nbits - 1 && wait_to) begin
        int  c;
        bit  seen;
        c = 0; seen = 0;
        for (int k = 1; k <= int'(T) + 20 && !seen; k++) begin
          @(posedge clk); #1;
          if (bus.byte_valid) check("timeout_no_valid", 32'd1, 32'd0);
          if (bus.frame_err) begin seen = 1; c = k; end
        end
        check("timeout_seen", {31'd0, seen}, 32'd1);
        check("timeout_latency", c, T + 3);
        @(posedge clk); #1;
        check("timeout_width", {31'd0, bus.frame_err}, 32'd0);
        check("timeout_byte_data", {24'd0, bus.byte_data}, {24'd0, last_byte});
        @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  logic [7:0] pool [16];

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'hF0, 8'hF0,
             8'hE0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'hF0, 8'h1D};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_keys", {26'd0, keys}, 32'd0);
    check("reset_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("reset_err", {31'd0, bus.frame_err}, 32'd0);
    check("reset_byte", {24'd0, bus.byte_data}, 32'd0);

    // Make W; hold A as a bystander; release W only
    good(8'h1D);
    check("w_held", {31'd0, bus.W_signal}, 32'd1);
    good(8'h1C);
    good(8'hF0);
    good(8'h1D);
    check("w_released", {31'd0, bus.W_signal}, 32'd0);
    check("a_kept", {31'd0, bus.A_signal}, 32'd1);
    good(8'hF0);
    good(8'h1C);

    // Bad parity on SPACE
    send_frame(8'h29, 1'b1, 11, 1'b0);
    check("space_not_set", {31'd0, bus.SPACE_signal}, 32'd0);

    // Partial frame then timeout, then clean A
    send_frame(8'h55, 1'b0, 5, 1'b1);
    good(8'h1C);
    check("a_after_timeout", {31'd0, bus.A_signal}, 32'd1);
    good(8'hF0);
    good(8'h1C);

    // Extended left arrow make/break, then plain A proves the sequencer is idle
    good(8'hE0);
    good(8'h6B);
`ifdef KEY_ARROW_ALIAS_EN
    check("arrow_make", {31'd0, bus.A_signal}, 32'd1);
`else
    check("arrow_make", {31'd0, bus.A_signal}, 32'd0);
`endif
    good(8'hE0);
    good(8'hF0);
    good(8'h6B);
    check("arrow_break", {31'd0, bus.A_signal}, 32'd0);
    good(8'h1C);
    check("idle_after_ext", {31'd0, bus.A_signal}, 32'd1);
    good(8'hF0);
    good(8'h1C);

    // Hold D and SPACE, reset mid-frame
    good(8'h23);
    good(8'h29);
    check("d_space_held", {26'd0, keys}, 32'h18);
    send_frame(8'hAA, 1'b0, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("rst_keys", {26'd0, keys}, 32'd0);
    check("rst_valid_err", {30'd0, bus.byte_valid, bus.frame_err}, 32'd0);
    check("rst_byte", {24'd0, bus.byte_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    good(8'h23);
    check("d_after_rst", {31'd0, bus.D_signal}, 32'd1);

    // Random byte stream with occasional parity faults
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit         bad;
      b   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, bad, 11, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
